// File: rtl/sreg_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer of PC/payload pairs with valid/ready and flush.
// Optional zero-latency empty-buffer bypass via `define SREG_STAGE_BYPASS_EN.
module sreg_stage_fifo #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sreg_stage_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             occ, byp, push, pop;

    assign occ      = (count != '0);
    assign in_ready = (count != FULL);

`ifdef SREG_STAGE_BYPASS_EN
    // Empty buffer forwards the producer straight through; a taken pair is never stored.
    assign byp = !occ && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = occ | byp;
    assign push      = in_valid & in_ready & ~(byp & out_ready);
    assign pop       = occ & out_ready;

    always_comb begin
        out_pc   = '0;
        out_data = '0;
        if (occ) begin
            out_pc   = mem[rd_ptr].pc;
            out_data = mem[rd_ptr].data;
        end else if (byp) begin
            out_pc   = in_pc;
            out_data = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush && push) begin
            mem[wr_ptr] <= '{pc: in_pc, data: in_data};
        end
    end

    // Flush drops any same-cycle push/pop; storage is left stale but unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sreg_stage_fifo.sv
// Scoreboard bench for sreg_stage_fifo (DEPTH=4); honours SREG_STAGE_BYPASS_EN when defined.
module tb_sreg_stage_fifo;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t sb[$];
    int     n_cmp = 0;
    int     n_err = 0;

    sreg_stage_fifo #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: compare mid-cycle, then apply the handshake the DUT sees at the next edge.
    int     m_sz;
    logic   m_byp;
    entry_t m_exp;
    always @(negedge clk) begin
        if (!rst) begin
            m_sz  = sb.size();
            m_byp = 1'b0;
`ifdef SREG_STAGE_BYPASS_EN
            m_byp = (m_sz == 0) && in_valid && !flush;
`endif
            m_exp = '0;
            if (m_sz != 0) m_exp = sb[0];
            else if (m_byp) m_exp = '{pc: in_pc, data: in_data};
            chk("in_ready",  64'(in_ready),  64'(m_sz != DEPTH));
            chk("out_valid", 64'(out_valid), 64'((m_sz != 0) || m_byp));
            chk("count",     64'(count),     64'(m_sz));
            chk("out_pc",    64'(out_pc),    64'(m_exp.pc));
            chk("out_data",  64'(out_data),  64'(m_exp.data));
            if (flush) begin
                sb.delete();
            end else begin
                if (m_sz != 0 && out_ready) void'(sb.pop_front());
                if (in_valid && m_sz != DEPTH && !(m_byp && out_ready))
                    sb.push_back('{pc: in_pc, data: in_data});
            end
        end
    end

    task automatic idle(input logic ordy, input int n);
        in_valid  = 1'b0;
        out_ready = ordy;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds the pair until the buffer takes it (bounded), then drops in_valid.
    task automatic send(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] d, input logic ordy);
        bit ok = 0;
        in_valid  = 1'b1;
        in_pc     = pc;
        in_data   = d;
        out_ready = ordy;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_count",     64'(count),     64'(0));
        chk("rst_out_pc",    64'(out_pc),    64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        @(negedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Single push with consumer ready
        send(32'h60, 32'h0050_0093, 1'b1);
        idle(1'b1, 2);

        // Fill and stall, then refused push while full, then drain in order
        for (int i = 0; i < DEPTH; i++) send(32'h60 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b0);
        in_valid = 1'b1; in_pc = 32'h70; in_data = 32'hA000_0070; out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send(32'h70, 32'hA000_0070, 1'b1);
        idle(1'b1, DEPTH + 2);
        chk("drain_empty", 64'(sb.size()), 64'(0));

        // Back-to-back streaming with wrap
        for (int i = 0; i < 10; i++) send(32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b1);
        idle(1'b1, 2);
        chk("stream_empty", 64'(sb.size()), 64'(0));

        // Flush with simultaneous push and pop
        send(32'h200, 32'hC000_0000, 1'b0);
        send(32'h204, 32'hC000_0001, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count",     64'(count),     64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        send(32'h300, 32'hD000_0000, 1'b1);
        idle(1'b1, 2);

        // Empty buffer, consumer ready: zero latency with bypass, one cycle otherwise
        send(32'h80, 32'hE000_0080, 1'b1);
        idle(1'b1, 2);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = 32'h1000 + 32'(4*i);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        idle(1'b1, DEPTH + 2);

        // Async reset mid-transfer
        send(32'h400, 32'hF000_0000, 1'b0);
        send(32'h404, 32'hF000_0001, 1'b0);
        in_valid = 1'b1; in_pc = 32'h408;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready",  64'(in_ready),  64'(1));
        chk("arst_count",     64'(count),     64'(0));
        chk("arst_out_pc",    64'(out_pc),    64'(0));
        chk("arst_out_data",  64'(out_data),  64'(0));
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk); #1; rst = 1'b0;
        idle(1'b1, 3);
        send(32'h500, 32'h1234_5678, 1'b1);
        idle(1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sreg_stage_fifo.md
Name: sreg_stage_fifo

Overview:
- Parametrised elastic pipeline-stage register, the successor to the fixed IF/ID stage register.
- Carries a PC and payload word from a producer stage to a consumer stage through a DEPTH-entry circular buffer.
- Uses valid/ready handshake, stall tolerance and synchronous flush on branch mispredict.
- Instantiated between any two pipeline stages (IF/ID first) so late memory responses and downstream stalls never drop or duplicate an instruction.

Parameters:
- DATA_W, 32, payload width (instruction word or stage bundle).
- PC_W, 32, PC field width.
- DEPTH, 2, buffer entries; power of two, >= 2; elaboration error otherwise.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous discard of all contents (branch mispredict).
- in_valid  input  1  producer has a PC/payload pair.
- in_ready  output  1  buffer accepts a push this cycle.
- in_pc  input  PC_W  producer PC.
- in_data  input  DATA_W  producer payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head this cycle.
- out_pc  output  PC_W  head PC.
- out_data  output  DATA_W  head payload.
- count  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- State: storage array, wr_ptr and rd_ptr (log2(DEPTH) bits each, wrap modulo DEPTH), count.
- Reset (asynchronous, rst=1): ptrs=0, count=0, all storage entries=0. Outputs: in_ready=1, out_valid=0, out_pc=0, out_data=0, count=0. Reset mid-transfer loses all entries and holds no residue.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on state, never on out_ready, so a full buffer refuses a push even when a pop occurs that cycle.
- out_valid = (count != 0). out_pc/out_data = entry[rd_ptr] when valid, 0 when empty.
- Latency: a push in cycle N appears at out_* in cycle N+1 at the earliest. Entries leave in FIFO order.
- Push only: write entry[wr_ptr], wr_ptr++, count++.
- Pop only: rd_ptr++, count--.
- Push & pop with 0<count<DEPTH: write, both ptrs advance, count unchanged.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.
- Flush (highest priority after reset): next cycle ptrs=0, count=0, out_valid=0. Any same-cycle push or pop is discarded. Storage contents need not be cleared. in_ready during the flush cycle still follows count.
- Held data: while out_valid=1 and out_ready=0, out_pc/out_data stay stable.
- Overflow and underflow cannot occur.
- No X-propagation: outputs are defined every cycle after reset.

Optional Feature:
- Macro SREG_STAGE_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0, out_valid=1 combinationally with out_pc=in_pc and out_data=in_data.
  - If out_ready=1 the pair is consumed without a write (count stays 0).
  - If out_ready=0 it is pushed normally.
  - Zero-latency path; the in->out combinational path is accepted.
- Undefined: no bypass; minimum latency 1 cycle as above.

Test Plan:
- Reset then idle: assert rst async mid-cycle -> immediately out_valid=0, count=0, in_ready=1, out_pc=0, out_data=0.
- Single push: in_pc=0x60, in_data=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x60, out_data=0x00500093; cycle after, count=0.
- Fill and stall, DEPTH=2: push 0x60 and 0x64 with out_ready=0 -> count=2, in_ready=0; third push of 0x68 is refused. Raise out_ready -> 0x60 then 0x64 delivered in order, then 0x68 accepted.
- Wrap with streaming, DEPTH=4: 10 back-to-back pushes with out_ready=1 -> all 10 PCs emerge in order with no bubbles after first output; count stays at most 1.
- Flush with simultaneous push/pop: count=2, flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, pushed PC never appears.
- Bypass (SREG_STAGE_BYPASS_EN defined): empty, in_valid=1, in_pc=0x80, out_ready=1 -> same cycle out_valid=1, out_pc=0x80; count remains 0.
